// File: rtl/pattern_pkg.sv
// Shared types and defaults for the pattern serializer and its sub-blocks.
package pattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int PATTERN_WORD_W_DEF = 8;

endpackage

// File: rtl/pattern_word_counter.sv
// Wrapping completed-word counter; advances by one on each cycle inc_i is high.
module pattern_word_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Count register; wraps naturally modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial feeder for the serial pattern detector.
// Words arrive on a valid/ready handshake and leave one bit per clock on
// out_bit, qualified by out_en. A new word may be accepted on the last-bit
// cycle of the current one so consecutive words stream without a gap.
// Bit order: LSB first by default; define PATTERN_SER_MSB_FIRST_EN for MSB first.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state and ser_en, never on in_valid;
// in_data is sampled only on that transfer edge.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WORD_W = PATTERN_WORD_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_bit,
  output logic              out_en,
  output logic              word_done,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WORD_W - 1);

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;    // bits still to be presented
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              out_bit_q, out_bit_d;
  logic              out_en_q, out_en_d;
  logic              last;
  logic              accept;

  assign last     = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
  assign in_ready = ser_en && ((state_q == IDLE) || last);
  assign accept   = in_valid && in_ready;

  // Next-state and datapath decode: load on accept, shift mid-word, retire on last bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    out_bit_d = out_bit_q;
    out_en_d  = out_en_q;
    if (accept) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      out_en_d  = 1'b1;
`ifdef PATTERN_SER_MSB_FIRST_EN
      out_bit_d = in_data[WORD_W-1];
      shreg_d   = {in_data[WORD_W-2:0], 1'b0};
`else
      out_bit_d = in_data[0];
      shreg_d   = {1'b0, in_data[WORD_W-1:1]};
`endif
    end else if ((state_q == SHIFT) && !last) begin
      bit_cnt_d = bit_cnt_q + BC_W'(1);
`ifdef PATTERN_SER_MSB_FIRST_EN
      out_bit_d = shreg_q[WORD_W-1];
      shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
`else
      out_bit_d = shreg_q[0];
      shreg_d   = {1'b0, shreg_q[WORD_W-1:1]};
`endif
    end else if (last) begin
      // Last bit presented and nothing new accepted: drop back to idle, line low.
      state_d   = IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      out_bit_d = 1'b0;
      out_en_d  = 1'b0;
    end
  end

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      out_bit_q <= 1'b0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      out_bit_q <= out_bit_d;
      out_en_q  <= out_en_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign out_en    = out_en_q;
  assign word_done = last;
  assign busy      = (state_q == SHIFT);

  pattern_word_counter #(
    .CNT_W(CNT_W)
  ) u_word_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (last),
    .count_o(words_sent)
  );

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: a per-cycle vector table covering single
// words, back-to-back streaming and ser_en gating, plus hand-written
// sequences for reset behaviour, mid-word async reset and bit order.
// Honours PATTERN_SER_MSB_FIRST_EN for the expected bit order.
module tb_pattern_serializer;

  logic        clk;
  logic        rst;
  logic        ser_en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_bit;
  logic        out_en;
  logic        word_done;
  logic        busy;
  logic [15:0] words_sent;

  int checks = 0;
  int errors = 0;

  pattern_serializer #(
    .WORD_W(8),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_en    (ser_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_bit   (out_bit),
    .out_en    (out_en),
    .word_done (word_done),
    .busy      (busy),
    .words_sent(words_sent)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ser_en;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        exp_en;
    logic        exp_bit;
    logic        exp_wd;
    logic        exp_rdy;
    logic [15:0] exp_cnt;
    int          tag;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] fill_cnt = '0;

  // k-th emitted bit of a word in the configured order.
  function automatic logic bit_of(input logic [7:0] w, input int k);
`ifdef PATTERN_SER_MSB_FIRST_EN
    return w[7-k];
`else
    return w[k];
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic v, input logic [7:0] d, input logic xen,
                     input logic xbit, input logic xwd, input logic xrdy, input int tag);
    vec_t r;
    r.ser_en = en; r.in_valid = v; r.in_data = d;
    r.exp_en = xen; r.exp_bit = xbit; r.exp_wd = xwd; r.exp_rdy = xrdy;
    r.exp_cnt = fill_cnt; r.tag = tag;
    vecs.push_back(r);
    if (xwd) fill_cnt++;
  endtask

  task automatic add_idle(input logic en, input logic v, input logic [7:0] d,
                          input logic xrdy, input int tag);
    add(en, v, d, 1'b0, 1'b0, 1'b0, xrdy, tag);
  endtask

  task automatic add_bit(input logic en, input logic v, input logic [7:0] d,
                         input logic [7:0] word, input int k, input int tag);
    add(en, v, d, 1'b1, bit_of(word, k), k == 7, (k == 7) && en, tag);
  endtask

  // Accept one word at the next edge, then check all eight bits and the idle cycle after.
  task automatic send_and_check(input logic [7:0] w, input logic [7:0] seq, input string nm,
                                input logic [15:0] cnt_after);
    in_valid = 1'b1; in_data = w; ser_en = 1'b1;
    #1 check({nm, " ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("%s en[%0d]", nm, k), out_en, 1'b1);
      check($sformatf("%s bit[%0d]", nm, k), out_bit, seq[k]);
      check($sformatf("%s done[%0d]", nm, k), word_done, k == 7);
      @(negedge clk);
    end
    #1;
    check({nm, " en_after"}, out_en, 1'b0);
    check({nm, " bit_after"}, out_bit, 1'b0);
    check({nm, " count"}, words_sent, cnt_after);
  endtask

  logic [7:0] seq_5a;
  logic [7:0] seq_80;

  initial begin
    rst = 1'b1; ser_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset held for two edges: everything idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_bit", out_bit, 1'b0);
    check("rst out_en", out_en, 1'b0);
    check("rst word_done", word_done, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst in_ready", in_ready, 1'b0);
    check("rst words_sent", words_sent, 16'd0);
    rst = 1'b0; ser_en = 1'b1;
    #1 check("post-rst in_ready", in_ready, 1'b1);

    // Single word 8'h06.
    add_idle(1, 1, 8'h06, 1, 2);
    for (int k = 0; k < 8; k++) add_bit(1, 0, 8'h00, 8'h06, k, 2);
    add_idle(1, 0, 8'h00, 1, 2);

    // Back-to-back 8'h0F then 8'hF0 with in_valid held; F0 taken on the last-bit cycle.
    add_idle(1, 1, 8'h0F, 1, 3);
    for (int k = 0; k < 8; k++) add_bit(1, 1, (k == 7) ? 8'hF0 : 8'h0F, 8'h0F, k, 3);
    for (int k = 0; k < 8; k++) add_bit(1, 0, 8'h00, 8'hF0, k, 3);
    add_idle(1, 0, 8'h00, 1, 3);

    // ser_en dropped at bit 3 of 8'hAA; 8'h55 waits until ser_en returns.
    add_idle(1, 1, 8'hAA, 1, 4);
    for (int k = 0; k < 3; k++) add_bit(1, 0, 8'h00, 8'hAA, k, 4);
    for (int k = 3; k < 8; k++) add_bit(0, 1, 8'h55, 8'hAA, k, 4);
    add_idle(0, 1, 8'h55, 0, 4);
    add_idle(0, 1, 8'h55, 0, 4);
    add_idle(1, 1, 8'h55, 1, 4);
    for (int k = 0; k < 8; k++) add_bit(1, 0, 8'h00, 8'h55, k, 4);
    add_idle(1, 0, 8'h00, 1, 4);

    foreach (vecs[i]) begin
      @(negedge clk);
      ser_en = vecs[i].ser_en; in_valid = vecs[i].in_valid; in_data = vecs[i].in_data;
      #1;
      check($sformatf("t%0d v%0d out_en", vecs[i].tag, i), out_en, vecs[i].exp_en);
      check($sformatf("t%0d v%0d out_bit", vecs[i].tag, i), out_bit, vecs[i].exp_bit);
      check($sformatf("t%0d v%0d word_done", vecs[i].tag, i), word_done, vecs[i].exp_wd);
      check($sformatf("t%0d v%0d in_ready", vecs[i].tag, i), in_ready, vecs[i].exp_rdy);
      check($sformatf("t%0d v%0d busy", vecs[i].tag, i), busy, vecs[i].exp_en);
      check($sformatf("t%0d v%0d words_sent", vecs[i].tag, i), words_sent, vecs[i].exp_cnt);
      if (!out_en) check($sformatf("t%0d v%0d idle_low", vecs[i].tag, i), out_bit, 1'b0);
    end

    // Async reset in the middle of 8'hFF (bit 4 on the line).
    @(negedge clk);
    ser_en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    repeat (4) @(negedge clk);
    #1;
    check("mid bit4 out_en", out_en, 1'b1);
    check("mid bit4 out_bit", out_bit, 1'b1);
    check("mid count", words_sent, 16'd5);
    #1 rst = 1'b1;
    #1;
    check("async out_en", out_en, 1'b0);
    check("async out_bit", out_bit, 1'b0);
    check("async busy", busy, 1'b0);
    check("async words_sent", words_sent, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) seq_5a[k] = bit_of(8'h5A, k);
    send_and_check(8'h5A, seq_5a, "after_rst", 16'd1);

    // Bit order of 8'h80 with hand-written expectations for each build.
`ifdef PATTERN_SER_MSB_FIRST_EN
    seq_80 = 8'b0000_0001;
`else
    seq_80 = 8'b1000_0000;
`endif
    send_and_check(8'h80, seq_80, "order80", 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
